shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter SHFT_LEN, default 5: shift-amount width per requester.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 req_valid  input  NREQ: bit i high means requester i presents an operation.
REQ-006 req_ready  output  NREQ: bit i high means requester i's operation is accepted this cycle.
REQ-007 req_x  input  32*NREQ: operand of requester i, at bits [32i+31:32i].
REQ-008 req_shamt  input  SHFT_LEN*NREQ: shift amount of requester i, at bits [SHFT_LEN*i+SHFT_LEN-1:SHFT_LEN*i].
REQ-009 rsp_valid  output  1: result register holds a valid result.
REQ-010 rsp_ready  input  1: consumer accepts the result this cycle.
REQ-011 rsp_data  output  32: shifted result.
REQ-012 rsp_id  output  3: index of the requester that produced rsp_data.

Function
REQ-013 The block SHALL share one 32-bit logical-left shifter (zero fill) among NREQ requesters, followed by a one-entry result register.
REQ-014 slot_free SHALL be (!rsp_valid || rsp_ready), evaluated combinationally.
REQ-015 The grant SHALL go to the first i with req_valid[i]=1, scanning from index ptr upward and wrapping modulo NREQ.
REQ-016 req_ready[i] SHALL be 1 only for the granted i, and only when slot_free=1 and rst=0; at most one req_ready bit SHALL be high per cycle.
REQ-017 A transfer SHALL occur when req_valid[i]&req_ready[i]; on the next edge rsp_valid=1, rsp_data=req_x[i]<<req_shamt[i] truncated to 32 bits, and rsp_id=i.
REQ-018 Latency SHALL be exactly 1 cycle from accept to rsp_valid; sustained throughput SHALL be 1 result per cycle while rsp_ready=1.
REQ-019 On a transfer, ptr SHALL become (i+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-020 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id SHALL hold stable and no requester SHALL be granted.
REQ-021 When a drain (rsp_valid&rsp_ready) and a transfer occur in the same cycle, the register SHALL load the new result and rsp_valid SHALL stay 1.
REQ-022 When a drain occurs with no transfer, rsp_valid SHALL go to 0 on the next edge; rsp_data and rsp_id SHALL hold their last values.
REQ-023 If SHFT_LEN>5 and shamt>=32, rsp_data SHALL be 0.
REQ-024 Requesters SHALL hold req_valid and operands stable until accepted; req_ready MAY depend combinationally on req_valid and rsp_ready.
REQ-025 With all NREQ requesters continuously valid and rsp_ready=1, each requester SHALL be granted exactly once in every NREQ consecutive grants.

Reset
REQ-026 rst SHALL take priority over all other inputs.
REQ-027 In any cycle with rst=1, req_ready SHALL be all 0; on the next edge rsp_valid=0, rsp_data=0, rsp_id=0 and ptr=0.
REQ-028 A result pending at reset SHALL be discarded, not delivered.
REQ-029 Operation SHALL resume normally in the first cycle after rst falls.

Verification
REQ-030 Single request: after reset, req_valid=0001, x0=0x0000_00FF, shamt0=4, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_data=0x0000_0FF0, rsp_id=0.
REQ-031 Round robin: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0,...; rsp_id follows the same order one cycle later, one result per cycle.
REQ-032 Backpressure: result pending, rsp_ready=0 for 3 cycles with req_valid=0010 -> req_ready=0 and rsp_data/rsp_id stable throughout; on the cycle rsp_ready=1, requester 1 is accepted in the same cycle and its result appears next cycle.
REQ-033 Edges: x=0x8000_0001 with shamt=0 -> 0x8000_0001; with shamt=31 -> 0x8000_0000; with shamt=1 -> 0x0000_0002.
REQ-034 Reset mid-operation: rst=1 asserted while rsp_valid=1, rsp_ready=0 and ptr=2 -> next cycle rsp_valid=0, rsp_data=0, rsp_id=0; with req_valid=1111 afterwards, the first grant goes to requester 0.
REQ-035 Fairness: random req_valid/rsp_ready for 10k cycles -> each result matches the reference x<<shamt tagged with the correct id, no result is lost or duplicated, and no continuously valid requester waits more than NREQ grants.

Source files
------------

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one 32-bit logical-left shifter (zero fill) among NREQ requesters.
//   A round-robin arbiter picks one valid requester per cycle. Its operand is
//   shifted and captured in a one-entry result register that a downstream
//   consumer drains through a valid/ready handshake.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   SHFT_LEN  width of each requester's shift amount
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   req_valid  [NREQ]           requester i presents an operation
//   req_ready  [NREQ]           requester i is accepted this cycle (one-hot or 0)
//   req_x      [32*NREQ]        operand of requester i at [32i+31:32i]
//   req_shamt  [SHFT_LEN*NREQ]  shift amount of requester i
//   rsp_valid                   result register holds a valid result
//   rsp_ready                   consumer takes the result this cycle
//   rsp_data   [32]             shifted result
//   rsp_id     [3]              index of the requester that produced rsp_data
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int NREQ     = 4,
    parameter int SHFT_LEN = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [32*NREQ-1:0]       req_x,
    input  logic [SHFT_LEN*NREQ-1:0] req_shamt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [2:0]               rsp_id
);

    // A 32-bit shift by 32 or more naturally yields zero, which covers wide
    // shift-amount fields without a separate range check.
    function automatic logic [31:0] shl(input logic [31:0]          x,
                                        input logic [SHFT_LEN-1:0]  s);
        return x << s;
    endfunction

    logic [2:0]          ptr;
    logic                slot_free;
    logic                found;
    logic                gnt_any;
    logic [2:0]          gnt_id;
    logic [2:0]          nxt_ptr;
    logic [31:0]         gnt_x;
    logic [SHFT_LEN-1:0] gnt_shamt;

    logic                vld_p1;
    logic [31:0]         data_p1;
    logic [2:0]          id_p1;

    assign slot_free = !vld_p1 || rsp_ready;

    // Round-robin pick: the valid requester with the smallest circular
    // distance from ptr wins.
    always_comb begin
        int d;
        int best_d;
        d         = 0;
        best_d    = NREQ;
        gnt_id    = '0;
        gnt_x     = '0;
        gnt_shamt = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + NREQ;
            if (req_valid[i] && d < best_d) begin
                best_d    = d;
                gnt_id    = 3'(i);
                gnt_x     = req_x[32*i +: 32];
                gnt_shamt = req_shamt[SHFT_LEN*i +: SHFT_LEN];
            end
        end
        found = (best_d < NREQ);
    end

    assign gnt_any = found && slot_free && !rst;
    assign nxt_ptr = (gnt_id == 3'(NREQ-1)) ? 3'd0 : gnt_id + 3'd1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = gnt_any && (gnt_id == 3'(i));
        end
    end

    // ---- Stage p1: result register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            ptr     <= '0;
        end else if (gnt_any) begin
            // Covers both a fresh load and a simultaneous drain-and-reload.
            vld_p1  <= 1'b1;
            data_p1 <= shl(gnt_x, gnt_shamt);
            id_p1   <= gnt_id;
            ptr     <= nxt_ptr;
        end else if (rsp_ready) begin
            // Drain without reload: data/id keep their last values.
            vld_p1  <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_data  = data_p1;
    assign rsp_id    = id_p1;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//   Self-checking bench for shift_arbiter: directed scenarios followed by
//   randomized traffic against a behavioural model (round-robin by circular
//   distance, an expected-result queue, and per-requester wait counters).
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    localparam int NREQ = 4;
    localparam int SL   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_x;
    logic [SL*NREQ-1:0]   req_shamt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic [2:0]           rsp_id;

    always #5 clk = ~clk;

    shift_arbiter #(.NREQ(NREQ), .SHFT_LEN(SL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state
    int           m_ptr  = 0;
    logic         m_vld  = 1'b0;
    logic [31:0]  m_data = '0;
    int           m_id   = 0;
    logic [NREQ-1:0] last_rdy;
    int           wcnt[NREQ];
    logic [34:0]  sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] x, input logic [SL-1:0] s);
        req_x[32*i +: 32]   = x;
        req_shamt[SL*i +: SL] = s;
    endtask

    // One clock cycle: inputs already driven; check at negedge, advance model,
    // return 1 time unit after the rising edge.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic [34:0] e;
        logic [31:0] x;
        logic [SL-1:0] s;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        if (!rst && (!m_vld || rsp_ready)) begin
            for (int d = 0; d < NREQ; d++) begin
                if (g < 0 && req_valid[(m_ptr + d) % NREQ]) g = (m_ptr + d) % NREQ;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", 32'(rsp_id), 32'(m_id));

        // Expected-result queue: every drained result must be the oldest
        // outstanding one, exactly once.
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra_result", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_data", rsp_data, e[31:0]);
                chk("sb_id", 32'(rsp_id), 32'(e[34:32]));
            end
        end

        // Fairness: grants to others while a requester waits stay below NREQ.
        for (int i = 0; i < NREQ; i++) begin
            if (rst || !req_valid[i] || i == g) begin
                wcnt[i] = 0;
            end else if (g >= 0) begin
                wcnt[i]++;
                chk("fair_wait", 32'(wcnt[i] < NREQ), 32'(1));
            end
        end

        if (rst) begin
            m_vld = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
            sb.delete();
        end else if (g >= 0) begin
            x = req_x[32*g +: 32];
            s = req_shamt[SL*g +: SL];
            m_data = (s >= 32) ? 32'h0 : (x << s);
            m_id   = g;
            m_vld  = 1'b1;
            m_ptr  = (g + 1) % NREQ;
            sb.push_back({3'(g), m_data});
        end else if (rsp_ready) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    logic [SL-1:0] e_sh[3];
    logic [31:0]   e_res[3];

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; req_shamt = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
        last_rdy = '0;
        @(posedge clk);
        #1;

        // Reset state, with every requester asserting valid during reset.
        req_valid = '1;
        rsp_ready = 1'b1;
        cycle();
        chk("rst_rdy", 32'(last_rdy), 32'(0));
        chk("rst_vld", 32'(rsp_valid), 32'(0));
        chk("rst_data", rsp_data, 32'h0);
        chk("rst_id", 32'(rsp_id), 32'(0));
        rst = 1'b0;

        // Single request.
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 32'h0000_00FF, 5'd4);
        req_valid = 4'b0001;
        cycle();
        chk("single_rdy", 32'(last_rdy), 32'(4'b0001));
        chk("single_vld", 32'(rsp_valid), 32'(1));
        chk("single_data", rsp_data, 32'h0000_0FF0);
        chk("single_id", 32'(rsp_id), 32'(0));
        req_valid = '0;
        cycle();
        chk("single_drain", 32'(rsp_valid), 32'(0));
        chk("single_hold", rsp_data, 32'h0000_0FF0);

        // Round robin with all requesters held valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 5'(i));
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2*NREQ; k++) begin
            cycle();
            chk("rr_gnt", 32'(last_rdy), 32'(1) << (k % NREQ));
            chk("rr_id", 32'(rsp_id), 32'(k % NREQ));
            chk("rr_vld", 32'(rsp_valid), 32'(1));
        end

        // Backpressure.
        do_reset();
        set_op(0, 32'h0000_1234, 5'd3);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        cycle();
        req_valid = 4'b0010;
        set_op(1, 32'h0000_00A5, 5'd8);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_rdy", 32'(last_rdy), 32'(0));
            chk("bp_data", rsp_data, 32'h0000_91A0);
            chk("bp_id", 32'(rsp_id), 32'(0));
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_acc", 32'(last_rdy), 32'(4'b0010));
        chk("bp_new_data", rsp_data, 32'h0000_A500);
        chk("bp_new_id", 32'(rsp_id), 32'(1));
        req_valid = '0;
        cycle();

        // Shift edge cases.
        do_reset();
        e_sh  = '{5'd0, 5'd31, 5'd1};
        e_res = '{32'h8000_0001, 32'h8000_0000, 32'h0000_0002};
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_op(0, 32'h8000_0001, e_sh[k]);
            cycle();
            chk("edge_data", rsp_data, e_res[k]);
        end
        req_valid = '0;
        cycle();

        // Reset while a result is pending and ptr=2.
        do_reset();
        set_op(1, 32'h7, 5'd1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        cycle();
        req_valid = '1;
        rst = 1'b1;
        cycle();
        chk("mr_rdy", 32'(last_rdy), 32'(0));
        chk("mr_vld", 32'(rsp_valid), 32'(0));
        chk("mr_data", rsp_data, 32'h0);
        chk("mr_id", 32'(rsp_id), 32'(0));
        rst = 1'b0;
        rsp_ready = 1'b1;
        cycle();
        chk("mr_first_gnt", 32'(last_rdy), 32'(4'b0001));

        // Randomized traffic; requesters hold operands until accepted.
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_rdy[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req_valid[i] = 1'b1;
                        set_op(i, $urandom, 5'($urandom_range(0, 31)));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("sb_leftover", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
